// File: rtl/speechrec_pkg.sv
// Shared types, default sizes and width helpers for the speech matcher.
package speechrec_pkg;

    localparam int unsigned N_SAMPLES_DEF   = 1000;
    localparam int unsigned N_TEMPLATES_DEF = 4;
    localparam int unsigned SAMPLE_W_DEF    = 10;

    // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough for N_SAMPLES terms of at most 2^sample_w - 1 each.
    function automatic int unsigned acc_width(input int unsigned sample_w, input int unsigned n);
        return sample_w + clog2_min1(n);
    endfunction

    localparam int unsigned ADDR_W_DEF = clog2_min1(N_SAMPLES_DEF);
    localparam int unsigned ACC_W_DEF  = acc_width(SAMPLE_W_DEF, N_SAMPLES_DEF);

    typedef enum logic [2:0] {
        StIdle,
        StPrime,
        StAccum,
        StCmp,
        StDone
    } state_e;

endpackage

// File: rtl/match_sequencer_if.sv
// Control, memory-read and result signals between the matcher and its neighbours.
interface match_sequencer_if
    import speechrec_pkg::*;
#(
    parameter int unsigned N_SAMPLES   = N_SAMPLES_DEF,
    parameter int unsigned N_TEMPLATES = N_TEMPLATES_DEF,
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF
) ();
    localparam int unsigned ADDR_W = clog2_min1(N_SAMPLES);
    localparam int unsigned IDX_W  = clog2_min1(N_TEMPLATES);
    localparam int unsigned ACC_W  = acc_width(SAMPLE_W, N_SAMPLES);

    logic                start;
    logic [ADDR_W-1:0]   rd_addr;
    logic [IDX_W-1:0]    tmpl_sel;
    logic [SAMPLE_W-1:0] sample_data;
    logic [SAMPLE_W-1:0] tmpl_data;
    logic                busy;
    logic                done;
    logic                result_valid;
    logic [IDX_W-1:0]    best_idx;
    logic [ACC_W-1:0]    best_score;

    // The matcher itself.
    modport master (
        input  start, sample_data, tmpl_data,
        output rd_addr, tmpl_sel, busy, done, result_valid, best_idx, best_score
    );

    // Capture RAM, template ROM and the results consumer.
    modport slave (
        output start, sample_data, tmpl_data,
        input  rd_addr, tmpl_sel, busy, done, result_valid, best_idx, best_score
    );
endinterface

// File: rtl/sad_accumulator.sv
// Running sum of absolute differences between two unsigned sample streams.
module sad_accumulator #(
    parameter int unsigned SAMPLE_W = 10,
    parameter int unsigned ACC_W    = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [SAMPLE_W-1:0] a_i,
    input  logic [SAMPLE_W-1:0] b_i,
    output logic [ACC_W-1:0]    acc_o
);
    logic [SAMPLE_W:0]   diff;
    logic [SAMPLE_W-1:0] mag;
    logic [ACC_W-1:0]    acc_q;

    // Signed difference one bit wider than the samples, then its magnitude.
    always_comb begin
        diff = {1'b0, a_i} - {1'b0, b_i};
        mag  = diff[SAMPLE_W] ? SAMPLE_W'(~diff + 1'b1) : diff[SAMPLE_W-1:0];
    end

    // Clear has priority so a new template always starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_W'(mag);
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/match_sequencer.sv
// Scores a captured utterance against each stored template and keeps the best match.
module match_sequencer
    import speechrec_pkg::*;
#(
    parameter int unsigned N_SAMPLES   = N_SAMPLES_DEF,
    parameter int unsigned N_TEMPLATES = N_TEMPLATES_DEF,
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF
) (
    input logic               clk,
    input logic               reset,
    match_sequencer_if.master bus
);
    localparam int unsigned ADDR_W = clog2_min1(N_SAMPLES);
    localparam int unsigned IDX_W  = clog2_min1(N_TEMPLATES);
    localparam int unsigned ACC_W  = acc_width(SAMPLE_W, N_SAMPLES);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_SAMPLES - 1);
    localparam logic [IDX_W-1:0]  LastTmpl = IDX_W'(N_TEMPLATES - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] j_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [IDX_W-1:0]  tmpl_sel_q;
    logic              busy_q;
    logic              done_q;
    logic              result_valid_q;
    logic [IDX_W-1:0]  best_idx_q;
    logic [ACC_W-1:0]  best_score_q;

    logic [ACC_W-1:0]  acc;
    logic              acc_clr;
    logic              acc_en;

    // Read address runs one ahead of j and parks on the last sample.
    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] a);
        return (a == LastAddr) ? a : a + 1'b1;
    endfunction

    assign acc_clr = (state_q == StPrime);
    assign acc_en  = (state_q == StAccum);

    sad_accumulator #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_sad (
        .clk   (clk),
        .reset (reset),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .a_i   (bus.sample_data),
        .b_i   (bus.tmpl_data),
        .acc_o (acc)
    );

    // Sequencer FSM with all externally visible outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            j_q            <= '0;
            rd_addr_q      <= '0;
            tmpl_sel_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            best_idx_q     <= '0;
            best_score_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q        <= StPrime;
                        tmpl_sel_q     <= '0;
                        rd_addr_q      <= '0;
                        busy_q         <= 1'b1;
                        result_valid_q <= 1'b0;
                        best_idx_q     <= '0;
                        best_score_q   <= '1;
                    end
                end
                StPrime: begin
                    // Address 0 is on the bus now; its data arrives in the first ACCUM cycle.
                    state_q   <= StAccum;
                    j_q       <= '0;
                    rd_addr_q <= sat_inc(rd_addr_q);
                end
                StAccum: begin
                    rd_addr_q <= sat_inc(rd_addr_q);
                    if (j_q == LastAddr) begin
                        state_q <= StCmp;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                StCmp: begin
                    // Strict compare: on a tie the earlier template stays best.
                    if (acc < best_score_q) begin
                        best_score_q <= acc;
                        best_idx_q   <= tmpl_sel_q;
                    end
                    rd_addr_q <= '0;
                    if (tmpl_sel_q == LastTmpl) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        tmpl_sel_q <= tmpl_sel_q + 1'b1;
                        state_q    <= StPrime;
                    end
                end
                StDone: begin
                    state_q        <= StIdle;
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b1;
                    tmpl_sel_q     <= '0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rd_addr      = rd_addr_q;
    assign bus.tmpl_sel     = tmpl_sel_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = result_valid_q;
    assign bus.best_idx     = best_idx_q;
    assign bus.best_score   = best_score_q;
endmodule

// File: tb/tb_match_sequencer.sv
// Directed, table-driven bench for match_sequencer with small memory models.
module tb_match_sequencer;
    localparam int unsigned NS = 4;
    localparam int unsigned NT = 3;
    localparam int unsigned SW = 10;

    typedef struct {
        int cap[NS];
        int tm[NT][NS];
        int exp_idx;
        int exp_score;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    int cap_mem[NS];
    int tm_mem[NT][NS];

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[4];

    always #5 clk = ~clk;

    match_sequencer_if #(
        .N_SAMPLES   (NS),
        .N_TEMPLATES (NT),
        .SAMPLE_W    (SW)
    ) bus ();

    match_sequencer #(
        .N_SAMPLES   (NS),
        .N_TEMPLATES (NT),
        .SAMPLE_W    (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous-read capture RAM and template ROM.
    always @(posedge clk) begin
        bus.sample_data <= SW'(cap_mem[bus.rd_addr]);
        bus.tmpl_data   <= SW'(tm_mem[bus.tmpl_sel][bus.rd_addr]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int s = 0; s < NS; s++) begin
            cap_mem[s] = v.cap[s];
            for (int t = 0; t < NT; t++) tm_mem[t][s] = v.tm[t][s];
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " done"}, 32'(bus.done), 0);
        chk({tag, " result_valid"}, 32'(bus.result_valid), 0);
        chk({tag, " best_idx"}, 32'(bus.best_idx), 0);
        chk({tag, " best_score"}, 32'(bus.best_score), 0);
        chk({tag, " rd_addr"}, 32'(bus.rd_addr), 0);
        chk({tag, " tmpl_sel"}, 32'(bus.tmpl_sel), 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 31 after the start edge.
    task automatic run(input string tag, input bit extra_starts, input int exp_idx,
                       input int exp_score);
        int first_done;
        int n_done;
        int rv_early;
        first_done = -1;
        n_done     = 0;
        rv_early   = 0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " busy@1"}, 32'(bus.busy), 1);
        chk({tag, " rv@1"}, 32'(bus.result_valid), 0);
        chk({tag, " score_init"}, 32'(bus.best_score), 4095);
        for (int c = 1; c <= 30; c++) begin
            if (bus.done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            if (bus.result_valid && first_done < 0) rv_early = 1;
            bus.start = extra_starts && (c == 3 || c == 10 || c == 19);
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, " done_cycle"}, 32'(first_done), 19);
        chk({tag, " done_pulses"}, 32'(n_done), 1);
        chk({tag, " rv_before_done"}, 32'(rv_early), 0);
        chk({tag, " best_idx"}, 32'(bus.best_idx), 32'(exp_idx));
        chk({tag, " best_score"}, 32'(bus.best_score), 32'(exp_score));
        chk({tag, " busy_end"}, 32'(bus.busy), 0);
        chk({tag, " rv_end"}, 32'(bus.result_valid), 1);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;

        // SADs 100, 1, 80.
        vecs[0].cap = '{10, 20, 30, 40};
        vecs[0].tm  = '{'{0, 0, 0, 0}, '{10, 20, 30, 41}, '{40, 30, 20, 10}};
        vecs[0].exp_idx = 1;  vecs[0].exp_score = 1;
        // Full-scale differences: 4 x 1023 = 4092, all tied so index 0 holds.
        vecs[1].cap = '{1023, 0, 1023, 0};
        vecs[1].tm  = '{'{0, 1023, 0, 1023}, '{0, 1023, 0, 1023}, '{0, 1023, 0, 1023}};
        vecs[1].exp_idx = 0;  vecs[1].exp_score = 4092;
        // T0 and T2 both exact: tie keeps the lower index.
        vecs[2].cap = '{5, 6, 7, 8};
        vecs[2].tm  = '{'{5, 6, 7, 8}, '{5, 6, 7, 9}, '{5, 6, 7, 8}};
        vecs[2].exp_idx = 0;  vecs[2].exp_score = 0;
        // SADs 1000, 400, 2: last template wins.
        vecs[3].cap = '{100, 200, 300, 400};
        vecs[3].tm  = '{'{0, 0, 0, 0}, '{100, 200, 300, 0}, '{99, 201, 300, 400}};
        vecs[3].exp_idx = 2;  vecs[3].exp_score = 2;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_zero("reset_idle");

        for (int i = 0; i < 4; i++) begin
            load(vecs[i]);
            run($sformatf("vec%0d", i), 1'b0, vecs[i].exp_idx, vecs[i].exp_score);
        end

        // Stray starts in cycles 3, 10 and 19 must be ignored.
        load(vecs[0]);
        run("ignored_start", 1'b1, vecs[0].exp_idx, vecs[0].exp_score);

        // Reset during ACCUM of T1 (cycles 8..11), then a clean rerun.
        load(vecs[3]);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_run tmpl_sel", 32'(bus.tmpl_sel), 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset busy", 32'(bus.busy), 0);
        run("after_reset", 1'b0, vecs[3].exp_idx, vecs[3].exp_score);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
